// File: rtl/pattern_player.sv
// pattern_player: plays a captured siteswap one throw per beat, tracking balls in a landing schedule.
// Define PLAYER_CATCH_COUNT_EN to add the saturating catch_count_out counter.
module pattern_player #(
  parameter int MAX_LEN    = 7,
  parameter int MAX_HEIGHT = 7
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    new_beat,
  input  logic [MAX_LEN-1:0][2:0] pattern_in,
  input  logic [2:0]              pattern_length,
  input  logic [2:0]              num_balls_in,
  input  logic                    pattern_valid_in,
  output logic                    throw_valid_out,
  output logic [2:0]              throw_height_out,
  output logic [2:0]              ball_id_out,
  output logic [2:0]              throw_index_out,
  output logic                    hand_out,
  output logic                    running_out,
  output logic                    error_out
`ifdef PLAYER_CATCH_COUNT_EN
  ,
  output logic [15:0]             catch_count_out
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, ERROR} state_t;
  state_t state;
  logic [MAX_LEN-1:0][2:0] pat;
  logic [2:0] len, nb, idx, intro;
  logic hand;
  logic [MAX_HEIGHT:0] slot_v, nv;
  logic [MAX_HEIGHT:0][2:0] slot_id, nid;
  logic valid_eff, capture, err;
  logic [2:0] h, ball;
  assign valid_eff = pattern_valid_in && pattern_length != 3'd0;
  assign capture = valid_eff && (state == IDLE || pattern_in != pat || pattern_length != len || num_balls_in != nb);
  assign h = pat[idx];
  assign ball = slot_v[0] ? slot_id[0] : intro;
  assign err = (h == 3'd0) ? slot_v[0] : (!(slot_v[0] || intro < nb) || slot_v[h]);
  // Throw into slot h, then shift: the ball ends up h-1 slots away.
  always_comb begin
    nv = {1'b0, slot_v[MAX_HEIGHT:1]};
    nid = {3'd0, slot_id[MAX_HEIGHT:1]};
    if (h != 3'd0) begin
      nv[h-3'd1] = 1'b1;
      nid[h-3'd1] = ball;
    end
  end
  always_ff @(posedge clk_in) begin
    throw_valid_out <= 1'b0;
    throw_height_out <= 3'd0;
    ball_id_out <= 3'd0;
    throw_index_out <= 3'd0;
    hand_out <= 1'b0;
    if (rst_in || !valid_eff) begin
      state <= IDLE;
      running_out <= 1'b0;
      error_out <= 1'b0;
      slot_v <= '0;
      slot_id <= '0;
      idx <= 3'd0;
      intro <= 3'd0;
      hand <= 1'b0;
      pat <= '0;
      len <= 3'd0;
      nb <= 3'd0;
`ifdef PLAYER_CATCH_COUNT_EN
      catch_count_out <= 16'd0;
`endif
    end else if (capture) begin
      state <= RUN;
      running_out <= 1'b1;
      error_out <= 1'b0;
      slot_v <= '0;
      slot_id <= '0;
      idx <= 3'd0;
      intro <= 3'd0;
      hand <= 1'b0;
      pat <= pattern_in;
      len <= pattern_length;
      nb <= num_balls_in;
`ifdef PLAYER_CATCH_COUNT_EN
      catch_count_out <= 16'd0;
`endif
    end else if (state == RUN && new_beat) begin
      if (err) begin
        state <= ERROR;
        running_out <= 1'b0;
        error_out <= 1'b1;
      end else begin
        throw_valid_out <= 1'b1;
        throw_height_out <= h;
        ball_id_out <= (h == 3'd0) ? 3'd0 : ball;
        throw_index_out <= idx;
        hand_out <= hand;
        slot_v <= nv;
        slot_id <= nid;
        idx <= (idx == len - 3'd1) ? 3'd0 : idx + 3'd1;
        hand <= ~hand;
        if (h != 3'd0 && !slot_v[0]) intro <= intro + 3'd1;
`ifdef PLAYER_CATCH_COUNT_EN
        if (h != 3'd0 && slot_v[0] && catch_count_out != 16'hFFFF) catch_count_out <= catch_count_out + 16'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_pattern_player.sv
// tb_pattern_player: scoreboard bench for pattern_player against a landing-time reference model.
module tb_pattern_player;
  logic clk_in = 1'b0, rst_in = 1'b1, new_beat = 1'b0, pattern_valid_in = 1'b0;
  logic [6:0][2:0] pattern_in = '0;
  logic [2:0] pattern_length = 3'd0, num_balls_in = 3'd0;
  logic throw_valid_out, hand_out, running_out, error_out;
  logic [2:0] throw_height_out, ball_id_out, throw_index_out;
`ifdef PLAYER_CATCH_COUNT_EN
  logic [15:0] catch_count_out;
`endif
  pattern_player dut (
    .clk_in(clk_in), .rst_in(rst_in), .new_beat(new_beat), .pattern_in(pattern_in),
    .pattern_length(pattern_length), .num_balls_in(num_balls_in), .pattern_valid_in(pattern_valid_in),
    .throw_valid_out(throw_valid_out), .throw_height_out(throw_height_out), .ball_id_out(ball_id_out),
    .throw_index_out(throw_index_out), .hand_out(hand_out), .running_out(running_out), .error_out(error_out)
`ifdef PLAYER_CATCH_COUNT_EN
    , .catch_count_out(catch_count_out)
`endif
  );
  always #5 clk_in = ~clk_in;
  int errors = 0, checks = 0;
  typedef struct {int h; int id; int idx; int hand;} ev_t;
  ev_t q[$];
  logic [6:0][2:0] lpat;
  int llen, lnb, midx, mhand, mintro, mt, mcatch;
  bit mact, mrun, merr;
  int lands[int];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end
  endtask
  task automatic mclear();
    mact = 0; mrun = 0; merr = 0; midx = 0; mhand = 0; mintro = 0; mcatch = 0; mt = 0;
    lands.delete(); lpat = '0; llen = 0; lnb = 0;
  endtask
  task automatic mcap(input logic [6:0][2:0] p, input int len, input int nb);
    mclear();
    mact = 1; mrun = 1; lpat = p; llen = len; lnb = nb;
  endtask
  // Balls are tracked by the absolute beat on which they land.
  task automatic model_beat();
    int h, b;
    ev_t e;
    bit land, bad;
    if (!mrun) return;
    h = int'(lpat[midx]);
    land = lands.exists(mt);
    bad = 0;
    b = 0;
    if (h == 0) bad = land;
    else begin
      if (land) b = lands[mt];
      else if (mintro < lnb) b = mintro;
      else bad = 1;
      if (lands.exists(mt + h)) bad = 1;
    end
    if (bad) begin
      mrun = 0; merr = 1;
      return;
    end
    if (h != 0) begin
      if (land) begin
        lands.delete(mt);
        mcatch++;
      end else mintro++;
      lands[mt + h] = b;
    end
    e.h = h; e.id = (h == 0) ? 0 : b; e.idx = midx; e.hand = mhand;
    q.push_back(e);
    midx = (midx + 1) % llen;
    mhand ^= 1;
    mt++;
  endtask
  task automatic status();
    chk("running", running_out, mrun);
    chk("error", error_out, merr);
`ifdef PLAYER_CATCH_COUNT_EN
    chk("catch_count", catch_count_out, mcatch);
`endif
  endtask
  task automatic load(input logic [6:0][2:0] p, input int len, input int nb, input bit with_beat);
    @(negedge clk_in);
    pattern_in = p; pattern_length = len[2:0]; num_balls_in = nb[2:0]; pattern_valid_in = 1; new_beat = with_beat;
    if (len == 0) mclear();
    else if (!mact || p != lpat || len != llen || nb != lnb) mcap(p, len, nb);
    else if (with_beat) model_beat();
    @(negedge clk_in);
    new_beat = 0;
    status();
  endtask
  task automatic beat(input int gap);
    @(negedge clk_in);
    new_beat = 1;
    model_beat();
    @(negedge clk_in);
    new_beat = 0;
    status();
    repeat (gap) @(negedge clk_in);
  endtask
  function automatic logic [6:0][2:0] pk(input int v[7]);
    logic [6:0][2:0] p;
    for (int i = 0; i < 7; i++) p[i] = v[i][2:0];
    return p;
  endfunction
  initial begin
    forever begin
      @(posedge clk_in);
      #1;
      if (throw_valid_out === 1'b1) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: got height %0d id %0d, expected none", throw_height_out, ball_id_out);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("height", throw_height_out, e.h);
          chk("ball_id", ball_id_out, e.id);
          chk("index", throw_index_out, e.idx);
          chk("hand", hand_out, e.hand);
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    mclear();
    repeat (3) @(negedge clk_in);
    chk("rst_valid", throw_valid_out, 0);
    chk("rst_running", running_out, 0);
    chk("rst_error", error_out, 0);
    rst_in = 0;
    load(pk('{0, 0, 0, 0, 0, 0, 0}), 0, 3, 0);
    load(pk('{3, 0, 0, 0, 0, 0, 0}), 1, 3, 0);
    repeat (10) beat(0);
    load(pk('{4, 4, 1, 0, 0, 0, 0}), 3, 3, 0);
    repeat (6) beat(1);
    load(pk('{4, 4, 1, 0, 0, 0, 0}), 3, 3, 1);
    beat(0);
    load(pk('{4, 0, 0, 0, 0, 0, 0}), 2, 2, 0);
    repeat (6) beat(0);
    load(pk('{4, 3, 0, 0, 0, 0, 0}), 2, 3, 0);
    repeat (3) beat(0);
    chk("err_43", error_out, 1);
    load(pk('{3, 0, 0, 0, 0, 0, 0}), 1, 3, 0);
    repeat (3) beat(0);
    load(pk('{5, 0, 0, 0, 0, 0, 0}), 1, 5, 1);
    repeat (4) beat(0);
    @(negedge clk_in);
    rst_in = 1;
    @(negedge clk_in);
    chk("midrst_valid", throw_valid_out, 0);
    chk("midrst_running", running_out, 0);
    chk("midrst_error", error_out, 0);
    rst_in = 0;
    mcap(pattern_in, 1, 5);
    @(negedge clk_in);
    status();
    repeat (3) beat(0);
    @(negedge clk_in);
    pattern_valid_in = 0;
    mclear();
    @(negedge clk_in);
    status();
    beat(0);
    for (int it = 0; it < 40; it++) begin
      int v[7], len, nb;
      len = $urandom_range(1, 7);
      if ($urandom_range(0, 1) == 1) begin
        nb = $urandom_range(1, 7);
        for (int i = 0; i < 7; i++) v[i] = nb;
      end else begin
        nb = $urandom_range(0, 7);
        for (int i = 0; i < 7; i++) v[i] = $urandom_range(0, 7);
      end
      load(pk(v), len, nb, $urandom_range(0, 3) == 0);
      for (int b = 0, n = $urandom_range(3, 20); b < n; b++) beat($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk_in);
        pattern_valid_in = 0;
        mclear();
        @(negedge clk_in);
        status();
      end
    end
    repeat (4) @(negedge clk_in);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d pending, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
